// File: rtl/burst_mem_responder.sv
// burst_mem_responder: behavioural burst memory with 256-bit lines moved as
// four 64-bit beats. Reads snapshot the addressed line into an in-order queue
// and return it READ_LATENCY cycles later as a gapless 4-beat burst. Writes
// collect four beats and commit the whole line when the last beat arrives.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   bmem_addr[31:0]      byte address; line index = addr[5 +: log2(LINES)]
//   bmem_read            read request
//   bmem_write           write beat valid
//   bmem_wdata[63:0]     write beat data
//   bmem_ready           request/beat accepted this cycle when high
//   bmem_resp            read response beat valid
//   bmem_rdata[63:0]     read response beat data (0 when idle)
//   bmem_raddr[31:0]     line address of the burst being returned (0 when idle)
//   proto_err            sticky protocol-violation flag
module burst_mem_responder #(
   parameter int unsigned READ_LATENCY = 4,
   parameter int unsigned QDEPTH       = 4,
   parameter int unsigned LINES        = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bmem_addr,
   input  logic        bmem_read,
   input  logic        bmem_write,
   input  logic [63:0] bmem_wdata,
   output logic        bmem_ready,
   output logic        bmem_resp,
   output logic [63:0] bmem_rdata,
   output logic [31:0] bmem_raddr,
   output logic        proto_err
);

   localparam int unsigned IW = $clog2(LINES);
   localparam int unsigned QW = $clog2(QDEPTH);
   localparam int unsigned CW = $clog2(QDEPTH + 1);
   localparam int unsigned LW = 4;
   localparam int unsigned AW = 27;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   // Backing store and queue payload (not reset)
   logic [255:0]  mem    [LINES];
   logic [255:0]  q_line [QDEPTH];
   logic [AW-1:0] q_addr [QDEPTH];

   // Registered state
   logic [0:0]    state_q, state_d;
   logic [1:0]    beat_q, beat_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [QW-1:0] head_q, head_d, tail_q, tail_d;
   logic [LW-1:0] lat_q [QDEPTH];
   logic [LW-1:0] lat_d [QDEPTH];
   logic [1:0]    wr_cnt_q, wr_cnt_d;
   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [191:0]  wr_buf_q, wr_buf_d;
   logic          ready_d, resp_d, err_d;
   logic [63:0]   rdata_d;
   logic [31:0]   raddr_d;

   // Combinational helpers
   logic [IW-1:0] line_idx;
   logic          wr_busy, wr_acc, rd_acc, last_beat, mem_we;
   logic [QW-1:0] cand, sel;
   logic          cand_avail, start_burst;
   logic [1:0]    beat_sel;
   logic [255:0]  line_sel;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^bmem_addr[4:0];

   // Next-state and output logic
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      occ_d       = occ_q;
      head_d      = head_q;
      tail_d      = tail_q;
      wr_cnt_d    = wr_cnt_q;
      wr_idx_d    = wr_idx_q;
      wr_buf_d    = wr_buf_q;
      err_d       = proto_err;
      lat_d       = lat_q;
      rdata_d     = 64'd0;
      raddr_d     = 32'd0;
      cand        = head_q;
      cand_avail  = 1'b0;
      start_burst = 1'b0;
      sel         = head_q;
      beat_sel    = 2'd0;
      line_sel    = 256'd0;
      mem_we      = 1'b0;

      line_idx  = bmem_addr[5 +: IW];
      wr_busy   = (wr_cnt_q != 2'd0);
      wr_acc    = bmem_write && bmem_ready;
      rd_acc    = bmem_read && !bmem_write && bmem_ready && !wr_busy;
      last_beat = (state_q == S_BURST) && (beat_q == 2'd3);

      // Next burst to launch: the entry behind the head when the current
      // burst ends this cycle (back-to-back), else the head when idle.
      if (last_beat) begin
         cand       = head_q + QW'(1);
         cand_avail = (occ_q >= CW'(2));
      end else if (state_q == S_IDLE) begin
         cand       = head_q;
         cand_avail = (occ_q >= CW'(1));
      end
      // Latency counter of 1 means the first beat is due next cycle
      start_burst = cand_avail && (lat_q[cand] <= LW'(1));

      case (state_q)
         S_IDLE:  if (start_burst) state_d = S_BURST;
         S_BURST: if (last_beat && !start_burst) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (start_burst)             beat_d = 2'd0;
      else if (state_q == S_BURST) beat_d = beat_q + 2'd1;

      sel      = start_burst ? cand : head_q;
      beat_sel = start_burst ? 2'd0 : beat_q + 2'd1;
      line_sel = q_line[sel];
      resp_d   = (state_d == S_BURST);
      if (resp_d) begin
         rdata_d = line_sel[{beat_sel, 6'd0} +: 64];
         raddr_d = {q_addr[sel], 5'd0};
      end

      // Queue pointers and occupancy
      if (last_beat) head_d = head_q + QW'(1);
      if (rd_acc)    tail_d = tail_q + QW'(1);
      occ_d = occ_q + CW'(rd_acc) - CW'(last_beat);

      for (int unsigned i = 0; i < QDEPTH; i++) begin
         if (lat_q[i] != LW'(0)) lat_d[i] = lat_q[i] - LW'(1);
      end
      if (rd_acc) lat_d[tail_q] = LW'(READ_LATENCY - 1);

      // Write beat collection; line index latched on beat 0
      if (wr_acc) begin
         wr_cnt_d = wr_cnt_q + 2'd1;
         case (wr_cnt_q)
            2'd0: begin
               wr_idx_d        = line_idx;
               wr_buf_d[63:0]  = bmem_wdata;
            end
            2'd1: wr_buf_d[127:64]  = bmem_wdata;
            2'd2: wr_buf_d[191:128] = bmem_wdata;
            default: mem_we = 1'b1;
         endcase
      end

      if (bmem_read && bmem_write) err_d = 1'b1;
      if (bmem_read && wr_busy)    err_d = 1'b1;
      if (wr_acc && wr_busy && (line_idx != wr_idx_q)) err_d = 1'b1;

      // Ready mirrors next-cycle registered occupancy; no dequeue bypass
      ready_d = (wr_cnt_d != 2'd0) || (occ_d < CW'(QDEPTH));
   end

   // Control and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         beat_q     <= 2'd0;
         occ_q      <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         wr_cnt_q   <= 2'd0;
         wr_idx_q   <= '0;
         wr_buf_q   <= '0;
         bmem_ready <= 1'b0;
         bmem_resp  <= 1'b0;
         bmem_rdata <= 64'd0;
         bmem_raddr <= 32'd0;
         proto_err  <= 1'b0;
         for (int unsigned i = 0; i < QDEPTH; i++) lat_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         occ_q      <= occ_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         wr_cnt_q   <= wr_cnt_d;
         wr_idx_q   <= wr_idx_d;
         wr_buf_q   <= wr_buf_d;
         bmem_ready <= ready_d;
         bmem_resp  <= resp_d;
         bmem_rdata <= rdata_d;
         bmem_raddr <= raddr_d;
         proto_err  <= err_d;
         lat_q      <= lat_d;
      end
   end

   // Store commit and read snapshot
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_idx_q] <= {bmem_wdata, wr_buf_q};
      if (rd_acc) begin
         q_line[tail_q] <= mem[line_idx];
         q_addr[tail_q] <= bmem_addr[31:5];
      end
   end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed testbench for burst_mem_responder (default parameters).
module tb_burst_mem_responder;

   logic        clk;
   logic        rst;
   logic [31:0] bmem_addr;
   logic        bmem_read;
   logic        bmem_write;
   logic [63:0] bmem_wdata;
   logic        bmem_ready;
   logic        bmem_resp;
   logic [63:0] bmem_rdata;
   logic [31:0] bmem_raddr;
   logic        proto_err;

   int n_checks = 0;
   int n_fail   = 0;

   burst_mem_responder dut (
      .clk        (clk),
      .rst        (rst),
      .bmem_addr  (bmem_addr),
      .bmem_read  (bmem_read),
      .bmem_write (bmem_write),
      .bmem_wdata (bmem_wdata),
      .bmem_ready (bmem_ready),
      .bmem_resp  (bmem_resp),
      .bmem_rdata (bmem_rdata),
      .bmem_raddr (bmem_raddr),
      .proto_err  (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic        exp_ready;
      logic        exp_resp;
      logic [63:0] exp_rdata;
      logic [31:0] exp_raddr;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [63:0] pat(input logic [7:0] b);
      return {8{b}};
   endfunction

   function automatic logic [255:0] line4(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
      return {pat(b3), pat(b2), pat(b1), pat(b0)};
   endfunction

   function automatic void add(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [63:0] wdata, input logic resp,
                               input logic [63:0] rdata, input logic [31:0] raddr);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
      v.exp_ready = 1'b1; v.exp_resp = resp; v.exp_rdata = rdata;
      v.exp_raddr = raddr; v.exp_err = 1'b0;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [63:0] wdata);
      bmem_read  = rd;
      bmem_write = wr;
      bmem_addr  = addr;
      bmem_wdata = wdata;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_ready"}, 64'(bmem_ready), 64'd0);
      chk({tag, "_resp"},  64'(bmem_resp),  64'd0);
      chk({tag, "_rdata"}, bmem_rdata,      64'd0);
      chk({tag, "_raddr"}, 64'(bmem_raddr), 64'd0);
      chk({tag, "_err"},   64'(proto_err),  64'd0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 64'd0);
      tick();
      chk_zero_outputs("reset");
      tick();
      rst = 1'b0;
      chk("ready_before_edge", 64'(bmem_ready), 64'd0);
      tick();
      chk("ready_after_edge", 64'(bmem_ready), 64'd1);
   endtask

   task automatic idle_no_resp(input string tag, input int n);
      drive(1'b0, 1'b0, 32'd0, 64'd0);
      for (int i = 0; i < n; i++) begin
         chk(tag, 64'(bmem_resp), 64'd0);
         tick();
      end
   endtask

   // Read one line and expect its burst READ_LATENCY (4) cycles later
   task automatic read_burst(input string tag, input logic [31:0] a, input logic [255:0] line);
      drive(1'b1, 1'b0, a, 64'd0);
      chk({tag, "_rd_ready"}, 64'(bmem_ready), 64'd1);
      tick();
      drive(1'b0, 1'b0, 32'd0, 64'd0);
      for (int i = 1; i < 4; i++) begin
         chk({tag, "_lat_resp"}, 64'(bmem_resp), 64'd0);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_b%0d_resp", tag, k), 64'(bmem_resp), 64'd1);
         chk($sformatf("%s_b%0d_rdata", tag, k), bmem_rdata, line[64*k +: 64]);
         chk($sformatf("%s_b%0d_raddr", tag, k), 64'(bmem_raddr), 64'({a[31:5], 5'd0}));
         tick();
      end
      chk({tag, "_end_resp"}, 64'(bmem_resp), 64'd0);
   endtask

   logic [255:0] l40, l80b, lc0, lde;
   logic [31:0]  a5 [5];

   initial begin
      l40  = line4(8'h11, 8'h22, 8'h33, 8'h44);
      l80b = line4(8'hB0, 8'hB1, 8'hB2, 8'hB3);
      lc0  = line4(8'hC0, 8'hC1, 8'hC2, 8'hC3);
      lde  = line4(8'hE0, 8'hE1, 8'hE2, 8'hE3);
      a5[0] = 32'h40; a5[1] = 32'h80; a5[2] = 32'h40; a5[3] = 32'h80; a5[4] = 32'h40;

      // Write 0x40, read it (T = vector 5), burst at T+4..T+7
      for (int k = 0; k < 4; k++) add(1'b0, 1'b1, 32'h40, pat(8'(8'h11 * (k + 1))), 1'b0, 64'd0, 32'd0);
      add(1'b1, 1'b0, 32'h40, 64'd0, 1'b0, 64'd0, 32'd0);
      for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 64'd0, 32'd0);
      for (int k = 0; k < 4; k++) add(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, pat(8'(8'h11 * (k + 1))), 32'h40);
      add(1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 64'd0, 32'd0);
      // Old data at 0x80, read it, overwrite before first beat, read again
      for (int k = 0; k < 4; k++) add(1'b0, 1'b1, 32'h80, pat(8'(8'hA0 + k)), 1'b0, 64'd0, 32'd0);
      add(1'b1, 1'b0, 32'h80, 64'd0, 1'b0, 64'd0, 32'd0);
      for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 32'h80, pat(8'(8'hB0 + k)), 1'b0, 64'd0, 32'd0);
      add(1'b0, 1'b1, 32'h80, pat(8'hB3), 1'b1, pat(8'hA0), 32'h80);
      add(1'b1, 1'b0, 32'h80, 64'd0, 1'b1, pat(8'hA1), 32'h80);
      add(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, pat(8'hA2), 32'h80);
      add(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, pat(8'hA3), 32'h80);
      add(1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 64'd0, 32'd0);
      for (int k = 0; k < 4; k++) add(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, pat(8'(8'hB0 + k)), 32'h80);
      add(1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 64'd0, 32'd0);

      apply_reset();

      foreach (vecs[i]) begin
         drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         chk($sformatf("vec%0d_ready", i), 64'(bmem_ready), 64'(vecs[i].exp_ready));
         chk($sformatf("vec%0d_resp", i),  64'(bmem_resp),  64'(vecs[i].exp_resp));
         chk($sformatf("vec%0d_rdata", i), bmem_rdata,      vecs[i].exp_rdata);
         chk($sformatf("vec%0d_raddr", i), 64'(bmem_raddr), 64'(vecs[i].exp_raddr));
         chk($sformatf("vec%0d_err", i),   64'(proto_err),  64'(vecs[i].exp_err));
         tick();
      end

      // Five reads on consecutive cycles; 5th stalls until burst 1's last beat
      for (int k = 0; k <= 30; k++) begin
         logic        exp_ready;
         logic [31:0] exp_raddr;
         logic [63:0] exp_rdata;
         logic        exp_resp;
         if (k < 4)       drive(1'b1, 1'b0, a5[k], 64'd0);
         else if (k <= 8) drive(1'b1, 1'b0, a5[4], 64'd0);
         else             drive(1'b0, 1'b0, 32'd0, 64'd0);
         exp_ready = (k < 4) || (k >= 8);
         if (k <= 8) chk($sformatf("q5_c%0d_ready", k), 64'(bmem_ready), 64'(exp_ready));
         exp_resp  = (k >= 4) && (k <= 23);
         exp_rdata = 64'd0;
         exp_raddr = 32'd0;
         if (exp_resp) begin
            exp_raddr = a5[(k - 4) / 4];
            exp_rdata = (exp_raddr == 32'h40) ? l40[64*((k - 4) % 4) +: 64]
                                              : l80b[64*((k - 4) % 4) +: 64];
         end
         chk($sformatf("q5_c%0d_resp", k),  64'(bmem_resp),  64'(exp_resp));
         chk($sformatf("q5_c%0d_rdata", k), bmem_rdata,      exp_rdata);
         chk($sformatf("q5_c%0d_raddr", k), 64'(bmem_raddr), 64'(exp_raddr));
         tick();
      end

      // Read and write together: taken as write beat 0, read dropped
      drive(1'b1, 1'b1, 32'hC0, pat(8'hC0));
      chk("rw_err_before", 64'(proto_err), 64'd0);
      tick();
      chk("rw_err_after", 64'(proto_err), 64'd1);
      for (int k = 1; k < 4; k++) begin
         drive(1'b0, 1'b1, 32'hC0, pat(8'(8'hC0 + k)));
         tick();
      end
      idle_no_resp("rw_no_burst", 8);
      read_burst("rw_line", 32'hC0, lc0);
      chk("rw_err_sticky", 64'(proto_err), 64'd1);
      tick();

      // Reset during read beat 2 and write beat 1
      read_burst_start: begin
         drive(1'b1, 1'b0, 32'h40, 64'd0);
         tick();
         drive(1'b0, 1'b0, 32'd0, 64'd0);
         repeat (4) tick();
         drive(1'b0, 1'b1, 32'h40, pat(8'hE0));
         chk("mid_beat1", bmem_rdata, pat(8'h22));
         tick();
         drive(1'b0, 1'b1, 32'h40, pat(8'hE1));
         chk("mid_beat2", bmem_rdata, pat(8'h33));
         #2;
         rst = 1'b1;
         #1;
         chk_zero_outputs("async_rst");
         drive(1'b0, 1'b0, 32'd0, 64'd0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         chk("mid_ready_hold", 64'(bmem_ready), 64'd0);
         tick();
         chk("mid_ready_rise", 64'(bmem_ready), 64'd1);
         idle_no_resp("mid_queue_empty", 8);
         read_burst("mid_line_kept", 32'h40, l40);
         tick();
      end

      // Read during a write burst is dropped and flagged
      apply_reset();
      drive(1'b0, 1'b1, 32'h100, pat(8'hD0));
      tick();
      drive(1'b1, 1'b0, 32'h40, 64'd0);
      chk("rdw_ready", 64'(bmem_ready), 64'd1);
      tick();
      chk("rdw_err", 64'(proto_err), 64'd1);
      for (int k = 1; k < 4; k++) begin
         drive(1'b0, 1'b1, 32'h100, pat(8'(8'hD0 + k)));
         tick();
      end
      idle_no_resp("rdw_no_burst", 8);

      // Address change mid-burst: latched line used, error flagged
      apply_reset();
      drive(1'b0, 1'b1, 32'h100, pat(8'hE0));
      tick();
      drive(1'b0, 1'b1, 32'h140, pat(8'hE1));
      chk("addr_err_before", 64'(proto_err), 64'd0);
      tick();
      chk("addr_err_after", 64'(proto_err), 64'd1);
      for (int k = 2; k < 4; k++) begin
         drive(1'b0, 1'b1, 32'h100, pat(8'(8'hE0 + k)));
         tick();
      end
      drive(1'b0, 1'b0, 32'd0, 64'd0);
      tick();
      read_burst("addr_latched", 32'h100, lde);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
